// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file.
//   - Default geometry: DefLanes lanes of DefLaneW bits, DefR0Init reset contents of register 0.
//   - vrf_state_t: initialisation sequencer states.
//   - lane_get / lane_merge: lane helpers for the default geometry.
package vrf_pkg;

  localparam int unsigned DefNumRegs = 16;
  localparam int unsigned DefLanes   = 8;
  localparam int unsigned DefLaneW   = 16;
  localparam int unsigned DefVw      = DefLanes * DefLaneW;

  localparam logic [DefVw-1:0] DefR0Init = 128'h000C000F00050001000B00030008000A;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } vrf_state_t;

  // Lane idx of a default-geometry vector.
  function automatic logic [DefLaneW-1:0] lane_get(input logic [DefVw-1:0] v,
                                                   input int unsigned idx);
    return v[idx*DefLaneW +: DefLaneW];
  endfunction

  // Lanes with mask bit set come from new_v, the rest from old_v.
  function automatic logic [DefVw-1:0] lane_merge(input logic [DefVw-1:0]    old_v,
                                                  input logic [DefVw-1:0]    new_v,
                                                  input logic [DefLanes-1:0] mask);
    logic [DefVw-1:0] res;
    res = old_v;
    for (int unsigned i = 0; i < DefLanes; i++) begin
      if (mask[i]) res[i*DefLaneW +: DefLaneW] = new_v[i*DefLaneW +: DefLaneW];
    end
    return res;
  endfunction

endpackage

// File: rtl/vrf_scoreboard.sv
// Per-register pending-write scoreboard.
//   clk, rst_n       : clock, asynchronous active-low reset (clears all busy bits)
//   clr_en, clr_idx  : clear the busy bit of clr_idx (a write has landed)
//   set_en, set_idx  : set the busy bit of set_idx (producer issued); wins over a same-index clear
//   ra1, ra2         : read taps
//   busy1, busy2     : registered busy bit for ra1 / ra2 (no same-cycle bypass)
// The top index is the PC alias and is never busy.
module vrf_scoreboard
  import vrf_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefNumRegs,
  localparam int unsigned AW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          busy1,
  output logic          busy2
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    // Applied after the clear so a same-index set wins.
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[NUM_REGS-1] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1 = busy_q[ra1];
  assign busy2 = busy_q[ra2];

endmodule

// File: rtl/vector_register_file.sv
// Vector register file for the SIMD decode stage.
//   clk, rst_n     : clock, asynchronous active-low reset
//   ra1/ra2        : read addresses; rd1/rd2 combinational read data
//   busy1/busy2    : registered scoreboard bit for ra1/ra2
//   we, wa, wmask, wd : lane-masked write port, bypassed to the read ports in the same cycle
//   sb_set, sb_idx : mark a register as having a pending producer
//   pc_in          : value returned for index NUM_REGS-1 (not stored)
//   ready          : initialisation sequence complete
// After reset a sequencer writes R0_INIT to register 0 and zeros to 1..NUM_REGS-2, one per
// cycle; writes, scoreboard sets and read data are suppressed until it finishes.
module vector_register_file
  import vrf_pkg::*;
#(
  parameter int unsigned NUM_REGS = DefNumRegs,
  parameter int unsigned LANES    = DefLanes,
  parameter int unsigned LANE_W   = DefLaneW,
  parameter logic [LANES*LANE_W-1:0] R0_INIT = DefR0Init,
  localparam int unsigned AW = $clog2(NUM_REGS),
  localparam int unsigned VW = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [VW-1:0]    rd1,
  output logic [VW-1:0]    rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [LANES-1:0] wmask,
  input  logic [VW-1:0]    wd,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_idx,
  input  logic [VW-1:0]    pc_in,
  output logic             ready
);

  localparam logic [AW-1:0] TopIdx  = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] LastIdx = AW'(NUM_REGS - 2);

  vrf_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          init_we;
  logic [VW-1:0] init_data;
  logic          wr_en;
  logic          sb_set_en;
  logic          sb_busy1, sb_busy2;

  // Storage for indices 0..NUM_REGS-2 only; no reset so it can map to LUT RAM.
  logic [VW-1:0] mem [NUM_REGS-1];

  // ---------------------------------------------------------------------------
  // Initialisation sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    unique case (state_q)
      INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == LastIdx) state_d = READY;
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready     = (state_q == READY);
  assign init_data = (cnt_q == '0) ? R0_INIT : '0;

  // Writes to the PC alias are dropped; they also never touch the scoreboard.
  assign wr_en     = ready && we && (wa != TopIdx);
  assign sb_set_en = ready && sb_set;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[cnt_q] <= init_data;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wmask[i]) mem[wa][i*LANE_W +: LANE_W] <= wd[i*LANE_W +: LANE_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: PC alias, otherwise stored data with per-lane write-through bypass
  // ---------------------------------------------------------------------------
  function automatic logic [VW-1:0] read_port(input logic [AW-1:0]    ra,
                                              input logic [VW-1:0]    stored,
                                              input logic             byp_en,
                                              input logic [AW-1:0]    byp_addr,
                                              input logic [LANES-1:0] byp_mask,
                                              input logic [VW-1:0]    byp_data,
                                              input logic [VW-1:0]    pc);
    logic [VW-1:0] v;
    v = stored;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (byp_en && (byp_addr == ra) && byp_mask[i]) begin
        v[i*LANE_W +: LANE_W] = byp_data[i*LANE_W +: LANE_W];
      end
    end
    if (ra == TopIdx) v = pc;
    return v;
  endfunction

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ready) begin
      rd1 = read_port(ra1, mem[ra1], wr_en, wa, wmask, wd, pc_in);
      rd2 = read_port(ra2, mem[ra2], wr_en, wa, wmask, wd, pc_in);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  vrf_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_en  (wr_en),
    .clr_idx (wa),
    .set_en  (sb_set_en),
    .set_idx (sb_idx),
    .ra1     (ra1),
    .ra2     (ra2),
    .busy1   (sb_busy1),
    .busy2   (sb_busy2)
  );

  assign busy1 = ready & sb_busy1;
  assign busy2 = ready & sb_busy2;

endmodule

// File: tb/tb_vector_register_file.sv
module tb_vector_register_file;
  import vrf_pkg::*;

  localparam int NR = 16;
  localparam int NL = 8;
  localparam int LW = 16;
  localparam logic [127:0] R0 = 128'h000C000F00050001000B00030008000A;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   ra1, ra2, wa, sb_idx;
  logic [127:0] rd1, rd2, wd, pc_in;
  logic         busy1, busy2, we, sb_set, ready;
  logic [7:0]   wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_register_file #(
    .NUM_REGS(NR),
    .LANES   (NL),
    .LANE_W  (LW),
    .R0_INIT (R0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra1    (ra1),
    .ra2    (ra2),
    .rd1    (rd1),
    .rd2    (rd2),
    .busy1  (busy1),
    .busy2  (busy2),
    .we     (we),
    .wa     (wa),
    .wmask  (wmask),
    .wd     (wd),
    .sb_set (sb_set),
    .sb_idx (sb_idx),
    .pc_in  (pc_in),
    .ready  (ready)
  );

  // Reference model: registers as arrays of lanes, scoreboard as a bit per register.
  logic [15:0] m_lane [NR][NL];
  bit          m_busy [NR];

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_busy[r] = 1'b0;
      for (int l = 0; l < NL; l++) m_lane[r][l] = (r == 0) ? lane_get(R0, l) : 16'h0;
    end
  endtask

  function automatic logic [127:0] model_read(input logic [3:0] ra);
    logic [127:0] v;
    if (ra == 4'(NR - 1)) return pc_in;
    for (int l = 0; l < NL; l++)
      v[l*LW +: LW] = (we && wa == ra && wmask[l]) ? lane_get(wd, l) : m_lane[ra][l];
    return v;
  endfunction

  task automatic model_edge();
    if (we && wa != 4'(NR - 1)) begin
      for (int l = 0; l < NL; l++) if (wmask[l]) m_lane[wa][l] = lane_get(wd, l);
      m_busy[wa] = 1'b0;
    end
    if (sb_set && sb_idx != 4'(NR - 1)) m_busy[sb_idx] = 1'b1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wmask = '0; wd = '0; sb_set = 1'b0; sb_idx = '0;
    ra1 = '0; ra2 = '0; pc_in = '0;
  endtask

  typedef struct {
    logic         we;
    logic [3:0]   wa;
    logic [7:0]   wmask;
    logic [127:0] wd;
    logic         sb_set;
    logic [3:0]   sb_idx;
    logic [3:0]   ra1, ra2;
    logic [127:0] pc;
    logic [127:0] e_rd1, e_rd2;
    logic         e_b1, e_b2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [7:0] m,
                              input logic [127:0] d, input logic s, input logic [3:0] si,
                              input logic [3:0] r1, input logic [3:0] r2, input logic [127:0] p,
                              input logic [127:0] e1, input logic [127:0] e2,
                              input logic b1, input logic b2);
    vec_t v;
    v.we = w; v.wa = a; v.wmask = m; v.wd = d; v.sb_set = s; v.sb_idx = si;
    v.ra1 = r1; v.ra2 = r2; v.pc = p; v.e_rd1 = e1; v.e_rd2 = e2; v.e_b1 = b1; v.e_b2 = b2;
    return v;
  endfunction

  localparam logic [127:0] Beef  = 128'h0000_0000_0000_0000_0000_BEEF_0000_BEEF;
  localparam logic [127:0] W2    = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
  localparam logic [127:0] W2hi  = 128'hAAAA_BBBB_CCCC_DDDD_0000_0000_0000_0000;
  localparam logic [127:0] R0mod = 128'h000C000F00050001000B000300087777;
  localparam logic [127:0] Xpc   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] Ones  = {128{1'b1}};

  initial begin
    bit seen;

    //       we  wa     mask   wd               sb  idx    ra1    ra2    pc    rd1    rd2   b1 b2
    vecs.push_back(mk(0, 4'd0,  8'h00, '0,              0, 4'd0,  4'd0,  4'd5,  '0,   R0,    '0,   0, 0));
    vecs.push_back(mk(1, 4'd3,  8'h05, {8{16'hBEEF}},   0, 4'd0,  4'd3,  4'd3,  '0,   Beef,  Beef, 0, 0));
    vecs.push_back(mk(0, 4'd0,  8'h00, '0,              0, 4'd0,  4'd3,  4'd0,  '0,   Beef,  R0,   0, 0));
    vecs.push_back(mk(1, 4'd2,  8'hF0, W2,              0, 4'd0,  4'd2,  4'd1,  '0,   W2hi,  '0,   0, 0));
    vecs.push_back(mk(0, 4'd0,  8'h00, '0,              0, 4'd0,  4'd3,  4'd2,  '0,   Beef,  W2hi, 0, 0));
    vecs.push_back(mk(1, 4'd0,  8'h01, {8{16'h7777}},   0, 4'd0,  4'd1,  4'd0,  '0,   '0,    R0mod,0, 0));
    vecs.push_back(mk(1, 4'd15, 8'hFF, {8{16'h5A5A}},   0, 4'd0,  4'd15, 4'd14, Xpc,  Xpc,   '0,   0, 0));
    vecs.push_back(mk(0, 4'd0,  8'h00, '0,              0, 4'd0,  4'd15, 4'd0,  Xpc,  Xpc,   R0mod,0, 0));
    vecs.push_back(mk(0, 4'd0,  8'h00, '0,              1, 4'd4,  4'd4,  4'd3,  '0,   '0,    Beef, 0, 0));
    vecs.push_back(mk(1, 4'd4,  8'h00, Ones,            1, 4'd4,  4'd4,  4'd4,  '0,   '0,    '0,   1, 1));
    vecs.push_back(mk(1, 4'd4,  8'h00, Ones,            0, 4'd0,  4'd4,  4'd2,  '0,   '0,    W2hi, 1, 0));
    vecs.push_back(mk(0, 4'd0,  8'h00, '0,              0, 4'd0,  4'd4,  4'd15, Xpc,  '0,    Xpc,  0, 0));
    vecs.push_back(mk(0, 4'd0,  8'h00, '0,              1, 4'd15, 4'd15, 4'd7,  '0,   '0,    '0,   0, 0));
    vecs.push_back(mk(0, 4'd0,  8'h00, '0,              1, 4'd7,  4'd15, 4'd7,  '0,   '0,    '0,   0, 0));
    vecs.push_back(mk(1, 4'd7,  8'hFF, W2,              0, 4'd0,  4'd15, 4'd7,  '0,   '0,    W2,   0, 1));
    vecs.push_back(mk(0, 4'd0,  8'h00, '0,              0, 4'd0,  4'd7,  4'd4,  '0,   W2,    '0,   0, 0));

    // Reset state, with a nonzero PC that must not leak through while not ready.
    idle_inputs();
    rst_n = 1'b0;
    ra1   = 4'd15;
    pc_in = Ones;
    #3;
    chk("reset ready", ready, 1'b0);
    chk("reset rd1", rd1, '0);
    chk("reset busy1", busy1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int e = 1; e <= 15; e++) begin
      cyc();
      chk($sformatf("init1 ready edge %0d", e), ready, (e == 15));
      if (e < 15) chk("init rd1 gated", rd1, '0);
    end
    idle_inputs();

    // Reset pulsed during INIT at cnt = 7.
    #2 rst_n = 1'b0;
    #1 @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (7) cyc();
    chk("pre-pulse ready", ready, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("mid-init reset ready", ready, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Writes and scoreboard sets driven during INIT must be ignored.
    we = 1'b1; wa = 4'd5; wmask = 8'hFF; wd = Ones; sb_set = 1'b1; sb_idx = 4'd5; ra1 = 4'd5;
    for (int e = 1; e <= 15; e++) begin
      cyc();
      if (e == 15) begin
        we = 1'b0;
        sb_set = 1'b0;
      end
      chk($sformatf("init2 ready edge %0d", e), ready, (e == 15));
    end
    #4;
    chk("init write ignored", rd1, '0);
    chk("init sb_set ignored", busy1, 1'b0);
    cyc();

    // Table-driven vectors.
    foreach (vecs[k]) begin
      we = vecs[k].we; wa = vecs[k].wa; wmask = vecs[k].wmask; wd = vecs[k].wd;
      sb_set = vecs[k].sb_set; sb_idx = vecs[k].sb_idx;
      ra1 = vecs[k].ra1; ra2 = vecs[k].ra2; pc_in = vecs[k].pc;
      #4;
      chk($sformatf("vec%0d rd1", k), rd1, vecs[k].e_rd1);
      chk($sformatf("vec%0d rd2", k), rd2, vecs[k].e_rd2);
      chk($sformatf("vec%0d busy1", k), busy1, vecs[k].e_b1);
      chk($sformatf("vec%0d busy2", k), busy2, vecs[k].e_b2);
      cyc();
    end

    // Reset while READY with a pending producer: everything re-initialises.
    idle_inputs();
    sb_set = 1'b1; sb_idx = 4'd6;
    cyc();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 chk("ready-state reset", ready, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int e = 0; e < 20 && !seen; e++) begin
      cyc();
      seen = ready;
    end
    chk("re-init ready within bound", seen, 1'b1);
    model_reset();
    ra1 = 4'd6; ra2 = 4'd3;
    #4;
    chk("re-init busy cleared", busy1, 1'b0);
    chk("re-init reg3 zero", rd2, '0);
    cyc();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we     = 1'($urandom_range(0, 1));
      wa     = 4'($urandom_range(0, 15));
      wmask  = 8'($urandom);
      wd     = {$urandom, $urandom, $urandom, $urandom};
      sb_set = ($urandom_range(0, 2) == 0);
      sb_idx = 4'($urandom_range(0, 15));
      ra1    = $urandom_range(0, 1) ? wa : 4'($urandom_range(0, 15));
      ra2    = $urandom_range(0, 1) ? sb_idx : 4'($urandom_range(0, 15));
      pc_in  = {$urandom, $urandom, $urandom, $urandom};
      #4;
      chk("rand rd1", rd1, model_read(ra1));
      chk("rand rd2", rd2, model_read(ra2));
      chk("rand busy1", busy1, m_busy[ra1]);
      chk("rand busy2", busy2, m_busy[ra2]);
      cyc();
      model_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_register_file.md
# vector_register_file

Parametrised vector register file for the SIMD datapath: NUM_REGS entries of LANES×LANE_W bits, two combinational read ports, and one lane-masked write port with same-cycle write-through bypass. The top index is not stored; it reads the externally supplied PC vector. After every reset, a sequencer loads reset contents one register per cycle, and a per-register scoreboard tracks pending writes for hazard detection. It sits in the decode stage and feeds the operand muxes and stall logic.

## Interface
- NUM_REGS, 16, register count including the PC alias at index NUM_REGS-1; power of two, ≥4
- LANES, 8, lanes per vector
- LANE_W, 16, bits per lane
- R0_INIT, 128'h000C000F00050001000B00030008000A, reset contents of register 0; width LANES*LANE_W
- Derived: AW = $clog2(NUM_REGS), VW = LANES*LANE_W
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  VW  read data
- busy1, busy2  out  1  scoreboard bit for ra1/ra2
- we  in  1  write enable
- wa  in  AW  write address
- wmask  in  LANES  per-lane write enable; bit i covers lane i, bits [i*LANE_W +: LANE_W]
- wd  in  VW  write data
- sb_set  in  1  mark sb_idx pending
- sb_idx  in  AW  register being issued a producer
- pc_in  in  VW  value returned for index NUM_REGS-1
- ready  out  1  initialisation complete

## Operation
- States: INIT, READY. rst_n low → INIT, init counter = 0, all busy bits = 0, asynchronously.
- INIT: each edge writes R0_INIT to reg 0 (cnt 0) or all-zeros to reg cnt (cnt 1..NUM_REGS-2), then cnt+1. On the edge writing cnt = NUM_REGS-2 → READY. we and sb_set are ignored in INIT.
- READY: terminal until next reset.
- Write: in READY with we=1 and wa≠NUM_REGS-1, lanes with wmask[i]=1 take wd; other lanes hold. Writes to NUM_REGS-1 are discarded. wmask=0 writes nothing but still clears busy.
- Read: ra=NUM_REGS-1 → pc_in. Otherwise: stored value, except lanes where (we && wa==ra && wmask[i] && READY) return wd lane i (bypass). Bypass applies independently per port.
- While not ready: rd1 = rd2 = 0, busy1 = busy2 = 0.
- Scoreboard: READY && we && wa valid → clear busy[wa]; READY && sb_set → set busy[sb_idx]. Same index set and clear in one cycle → set wins. busy[NUM_REGS-1] is constant 0; sb_set to it is ignored.
- busyN = busy[raN], registered value only; no bypass of the same-cycle set or clear.

## Timing
- Reset values: ready=0, rd1=rd2=0, busy1=busy2=0, state INIT, all busy bits 0. Array contents are undefined until written by INIT.
- ready rises after NUM_REGS-1 rising edges following rst_n deassertion (15 for the default).
- Write latency: visible combinationally the same cycle via bypass and from storage after the edge.
- Scoreboard latency: set or clear visible on busyN one cycle after the edge.
- Reset asserted mid-INIT or in READY: immediate return to INIT and full re-initialisation. In-flight writes are lost.

## Structure
- Package vrf_pkg: default LANES, LANE_W, R0_INIT, vrf_state_t enum {INIT, READY}, lane extract/merge functions.
- Sub-module vrf_scoreboard: busy vector, set/clear priority, and two read taps. Parameter NUM_REGS; same clk and rst_n.
- Storage is a plain array with no reset, so it can map to LUT RAM. Only the FSM, counter, and busy bits are reset.

## Test plan
- Reset release, default params: ready=0 for 14 edges and 1 after the 15th; then ra1=0 → 000C000F00050001000B00030008000A, ra2=5 → 0.
- we=1, wa=3, wmask=8'b0000_0101, wd=all lanes 16'hBEEF, ra1=3 same cycle → rd1 lanes 0 and 2 = BEEF, others 0. The next cycle gives the same result from storage.
- ra1=15, pc_in=X; we=1, wa=15, wd=Y → rd1=X before and after; no storage change.
- sb_set idx=4 → busy1(ra1=4)=1 next cycle. Then we wa=4 together with sb_set idx=4 → stays 1. Then we wa=4 alone → 0.
- Reset pulsed during INIT at cnt=7 → ready=0 and counter restarts; ready high exactly 15 edges after the second release.
- we=1 and sb_set asserted during INIT → no write and no busy set once READY.
